regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (RegWrite/WriteRegister/WriteData)
//  between NUM_REQ write-back requesters (e.g. ALU result, load unit, mul/div unit).
//  Round-robin arbitration, valid/ready per requester, one registered output stage
//  feeding the register file. Also reports read-after-write hazards on two decode-side
//  read addresses so the pipeline can stall until a pending write has landed.
// PARAMETERS
//  NUM_REQ  2   number of write-back requesters (>=2)
//  DATA_W   32  register data width
//  ADDR_W   5   register address width (32 registers, r0 hardwired zero)
// PORTS
//  clock          in   1               system clock, all state on posedge
//  reset_n        in   1               asynchronous, active-low reset
//  req_valid      in   NUM_REQ         requester i has a write pending
//  req_ready      out  NUM_REQ         request i accepted this cycle
//  req_addr       in   NUM_REQ*ADDR_W  dest register of requester i (slice i)
//  req_data       in   NUM_REQ*DATA_W  write data of requester i (slice i)
//  RegWrite       out  1               register-file write enable (registered)
//  WriteRegister  out  ADDR_W          register-file write address (registered)
//  WriteData      out  DATA_W          register-file write data (registered)
//  chk_addr1      in   ADDR_W          decode read address 1 to check
//  chk_addr2      in   ADDR_W          decode read address 2 to check
//  hazard1        out  1               pending write targets chk_addr1
//  hazard2        out  1               pending write targets chk_addr2
// BEHAVIOUR
//  - Reset (async, reset_n=0): RegWrite=0, WriteRegister=0, WriteData=0, rr pointer=0.
//    Asserting reset mid-operation drops the output stage immediately; no write issues.
//  - Handshake: accept when req_valid[i] && req_ready[i]. Requester holds valid/addr/data
//    stable until accepted; deasserting valid before ready is a protocol violation.
//  - Output stage never stalls (register file always accepts), so at most one nonzero-
//    address request is granted per cycle, and ready for it is asserted combinationally.
//  - Arbitration: among valid requests with addr!=0, grant first index at or after rr
//    pointer (wrapping). On grant to i: pointer <= (i+1) mod NUM_REQ. No grant: pointer holds.
//  - r0 filtering: every valid request with addr==0 gets ready=1 in the same cycle,
//    in parallel with the nonzero grant; it never reaches the output stage, never moves
//    the pointer.
//  - Latency: grant in cycle t -> RegWrite=1 with that addr/data during cycle t+1 ->
//    register file updated at the edge ending t+1. RegWrite is 1 only in cycles after a grant.
//  - Same dest from two requesters: written in grant order; last grant wins.
//  - hazardK (combinational) = chk_addrK!=0 && ( any req_valid[i] with req_addr[i]==chk_addrK
//    || (RegWrite && WriteRegister==chk_addrK) ). Clears the cycle after the write lands.
// STRUCTURE
//  - Package regfile_pkg: ADDR_W, DATA_W, REG_ZERO (=0), NUM_REGS (=32).
//  - Sub-module rr_arbiter: NUM_REQ request vector in, one-hot grant out, internal pointer
//    advanced on grant; top instantiates it on (req_valid & addr!=0).
// TESTING
//  1 reset_n=0 while RegWrite=1 -> RegWrite=0 same cycle; after release, first grant is req0.
//  2 req0 addr=5 data=32'hDEADBEEF alone -> ready0=1 cycle t; cycle t+1 RegWrite=1,
//    WriteRegister=5, WriteData=DEADBEEF; RegWrite=0 at t+2.
//  3 req0 (addr 3) and req1 (addr 4) held valid, 8 cycles -> grants 0,1,0,1,...; one write each.
//  4 req0 addr=7, req1 addr=0 same cycle -> both ready; only r7 written; pointer -> 1.
//  5 req0 addr=9 waiting behind req1 grant, chk_addr1=9, chk_addr2=0 -> hazard1=1 until the
//    cycle after RegWrite for r9; hazard2=0 throughout.
//  6 both addr=12, data 32'hA / 32'hB, pointer=0 -> r12 written A then B; read back 32'hB.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: register file geometry shared by the write-back arbiter, its bus interface and bench
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: write-back requester bus, register-file write port and hazard check
//   master: drives req_valid/req_addr/req_data (slice i per requester) and chk_addr1/2
//   slave : drives req_ready, RegWrite/WriteRegister/WriteData and hazard1/2
interface regfile_wb_arbiter_if import regfile_pkg::*; #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic hazard1;
  logic hazard2;
  modport master (
    output req_valid, req_addr, req_data, chk_addr1, chk_addr2,
    input req_ready, RegWrite, WriteRegister, WriteData, hazard1, hazard2
  );
  modport slave (
    input req_valid, req_addr, req_data, chk_addr1, chk_addr2,
    output req_ready, RegWrite, WriteRegister, WriteData, hazard1, hazard2
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; ports clock, reset_n, req (request vector), gnt (one-hot grant)
module rr_arbiter #(parameter int NUM_REQ = 2) (
  input logic clock,
  input logic reset_n,
  input logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);
  // The pointer is kept as a mask of indices at or after it; all ones is pointer 0.
  logic [NUM_REQ-1:0] mask, masked, pick;
  assign masked = req & mask;
  assign pick = |masked ? masked : req;
  assign gnt = pick & (~pick + NUM_REQ'(1));
  // Granting the top index leaves an empty mask, which wraps to index 0 like pointer 0.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) mask <= '1;
    else if (|gnt) mask <= ~((gnt << 1) - NUM_REQ'(1));
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port with RAW hazard report
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (slave)    : requester valid/ready/addr/data, registered RegWrite/WriteRegister/WriteData,
//                    decode check addresses chk_addr1/2 and hazard1/2
module regfile_wb_arbiter import regfile_pkg::*; #(parameter int NUM_REQ = 2) (
  input logic clock,
  input logic reset_n,
  regfile_wb_arbiter_if.slave bus
);
  logic [NUM_REQ-1:0] nz, gnt, hit1, hit2;
  logic [ADDR_W-1:0] addr_or [NUM_REQ+1];
  logic [DATA_W-1:0] data_or [NUM_REQ+1];
  assign addr_or[0] = REG_ZERO;
  assign data_or[0] = '0;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    assign a = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign d = bus.req_data[g*DATA_W +: DATA_W];
    assign nz[g] = bus.req_valid[g] && a != REG_ZERO;
    assign hit1[g] = bus.req_valid[g] && a == bus.chk_addr1;
    assign hit2[g] = bus.req_valid[g] && a == bus.chk_addr2;
    // Grant is one-hot, so an AND-OR chain is the output mux.
    assign addr_or[g+1] = addr_or[g] | (gnt[g] ? a : REG_ZERO);
    assign data_or[g+1] = data_or[g] | (gnt[g] ? d : '0);
  end
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock(clock),
    .reset_n(reset_n),
    .req(nz),
    .gnt(gnt)
  );
  // Writes to r0 are swallowed: acknowledged at once alongside the real grant.
  assign bus.req_ready = gnt | (bus.req_valid & ~nz);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      bus.RegWrite <= 1'b0;
      bus.WriteRegister <= REG_ZERO;
      bus.WriteData <= '0;
    end else begin
      bus.RegWrite <= |gnt;
      bus.WriteRegister <= addr_or[NUM_REQ];
      bus.WriteData <= data_or[NUM_REQ];
    end
  assign bus.hazard1 = bus.chk_addr1 != REG_ZERO &&
    (|hit1 || (bus.RegWrite && bus.WriteRegister == bus.chk_addr1));
  assign bus.hazard2 = bus.chk_addr2 != REG_ZERO &&
    (|hit2 || (bus.RegWrite && bus.WriteRegister == bus.chk_addr2));
endmodule
